// File: rtl/card_pkg.sv
// Card types and scoring helpers shared by the hand datapath and the round FSM.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_TEN   = 4'd10;
  localparam card_t CARD_KING  = 4'd13;

  // Baccarat point value: 1..9 count at face, everything else (empty, tens, faces, illegal) is 0.
  function automatic logic [3:0] card_value(input card_t card);
    return ((card >= CARD_ACE) && (card < CARD_TEN)) ? card : 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(input card_t c1, input card_t c2, input card_t c3);
    logic [4:0] sum;
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    if (sum >= 5'd20) begin
      sum = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      sum = sum - 5'd10;
    end
    return sum[3:0];
  endfunction

endpackage

// File: rtl/card7seg.sv
// Active-low 7-segment glyph for one card slot; bit 0 is segment a, bit 6 is segment g.
module card7seg
  import card_pkg::*;
(
  input  card_t      card,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (card)
      4'd1:    seg = 7'b0001000; // A
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      4'd10:   seg = 7'b1000000; // ten shown as 0
      4'd11:   seg = 7'b1100001; // J
      4'd12:   seg = 7'b0011000; // q
      4'd13:   seg = 7'b0001001; // K
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/hand_datapath.sv
// Card source, six hand slots, slot counts and mod-10 scores for the baccarat round FSM.
// Define HAND_HEX_EN to add HEX0..HEX5 seven-segment outputs for the six slots.
module hand_datapath
  import card_pkg::*;
#(
  parameter int unsigned RANK_MAX  = 13,
  parameter int unsigned DECK_SEED = 1
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  input  logic       deal_hold,
  output card_t      new_card,
  output card_t      pcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [1:0] pcount,
  output logic [1:0] dcount
`ifdef HAND_HEX_EN
  ,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
`endif
);

  localparam card_t RankMax  = card_t'(RANK_MAX);
  localparam card_t DeckSeed = card_t'(DECK_SEED);

  card_t           src_q;
  card_t     [2:0] pslot_q;
  card_t     [2:0] dslot_q;
  logic      [1:0] pcount_q;
  logic      [1:0] dcount_q;
  logic      [2:0] pload;
  logic      [2:0] dload;
  logic      [1:0] pinc;
  logic      [1:0] dinc;
  logic            src_bad;

  assign pload   = {load_pcard3, load_pcard2, load_pcard1};
  assign dload   = {load_dcard3, load_dcard2, load_dcard1};
  assign src_bad = (src_q == CARD_EMPTY) || (src_q > RankMax);

  // Only loads into empty slots add to the count; overwrites leave it alone.
  always_comb begin
    pinc = 2'd0;
    dinc = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (pload[i] && (pslot_q[i] == CARD_EMPTY)) pinc = pinc + 2'd1;
      if (dload[i] && (dslot_q[i] == CARD_EMPTY)) dinc = dinc + 2'd1;
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      src_q    <= DeckSeed;
      pslot_q  <= '0;
      dslot_q  <= '0;
      pcount_q <= 2'd0;
      dcount_q <= 2'd0;
    end else begin
      // A corrupted source recovers to ace even while held.
      if (src_bad) begin
        src_q <= CARD_ACE;
      end else if (!deal_hold) begin
        src_q <= (src_q == RankMax) ? CARD_ACE : src_q + 4'd1;
      end
      for (int i = 0; i < 3; i++) begin
        if (pload[i]) pslot_q[i] <= src_q;
        if (dload[i]) dslot_q[i] <= src_q;
      end
      pcount_q <= pcount_q + pinc;
      dcount_q <= dcount_q + dinc;
    end
  end

  assign new_card = src_q;
  assign pcard3   = pslot_q[2];
  assign pscore   = hand_score(pslot_q[0], pslot_q[1], pslot_q[2]);
  assign dscore   = hand_score(dslot_q[0], dslot_q[1], dslot_q[2]);
  assign pcount   = pcount_q;
  assign dcount   = dcount_q;

`ifdef HAND_HEX_EN
  card7seg u_hex0 (.card(pslot_q[0]), .seg(HEX0));
  card7seg u_hex1 (.card(pslot_q[1]), .seg(HEX1));
  card7seg u_hex2 (.card(pslot_q[2]), .seg(HEX2));
  card7seg u_hex3 (.card(dslot_q[0]), .seg(HEX3));
  card7seg u_hex4 (.card(dslot_q[1]), .seg(HEX4));
  card7seg u_hex5 (.card(dslot_q[2]), .seg(HEX5));
`endif

endmodule

// File: tb/tb_hand_datapath.sv
// Self-checking bench for hand_datapath: directed scenarios plus a random run against a card model.
module tb_hand_datapath;

  localparam int RankMax  = 13;
  localparam int DeckSeed = 1;

  logic       slow_clock = 1'b0;
  logic       reset;
  logic [2:0] ld_p;
  logic [2:0] ld_d;
  logic       deal_hold;
  logic [3:0] new_card;
  logic [3:0] pcard3;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [1:0] pcount;
  logic [1:0] dcount;
`ifdef HAND_HEX_EN
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_src;
  int m_p[3];
  int m_d[3];
  int m_pc;
  int m_dc;

  always #5 slow_clock = ~slow_clock;

  hand_datapath #(
    .RANK_MAX (RankMax),
    .DECK_SEED(DeckSeed)
  ) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .load_pcard1(ld_p[0]),
    .load_pcard2(ld_p[1]),
    .load_pcard3(ld_p[2]),
    .load_dcard1(ld_d[0]),
    .load_dcard2(ld_d[1]),
    .load_dcard3(ld_d[2]),
    .deal_hold  (deal_hold),
    .new_card   (new_card),
    .pcard3     (pcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .pcount     (pcount),
    .dcount     (dcount)
`ifdef HAND_HEX_EN
    ,
    .HEX0       (hex0),
    .HEX1       (hex1),
    .HEX2       (hex2),
    .HEX3       (hex3),
    .HEX4       (hex4),
    .HEX5       (hex5)
`endif
  );

  function automatic int val(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs, then clock the DUT.
  task automatic tick();
    if (reset) begin
      m_src = DeckSeed;
      m_pc  = 0;
      m_dc  = 0;
      for (int i = 0; i < 3; i++) begin
        m_p[i] = 0;
        m_d[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ld_p[i]) begin
          if (m_p[i] == 0) m_pc++;
          m_p[i] = m_src;
        end
        if (ld_d[i]) begin
          if (m_d[i] == 0) m_dc++;
          m_d[i] = m_src;
        end
      end
      if (!deal_hold) m_src = (m_src % RankMax) + 1;
    end
    @(posedge slow_clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".new_card"}, 8'(new_card), 8'(m_src));
    check({tag, ".pcard3"},   8'(pcard3),   8'(m_p[2]));
    check({tag, ".pscore"},   8'(pscore),   8'((val(m_p[0]) + val(m_p[1]) + val(m_p[2])) % 10));
    check({tag, ".dscore"},   8'(dscore),   8'((val(m_d[0]) + val(m_d[1]) + val(m_d[2])) % 10));
    check({tag, ".pcount"},   8'(pcount),   8'(m_pc));
    check({tag, ".dcount"},   8'(dcount),   8'(m_dc));
  endtask

  task automatic advance_to(input int v);
    int n = 0;
    while (m_src != v && n < 2 * RankMax) begin
      tick();
      n++;
    end
    check("advance_to", 8'(new_card), 8'(v));
  endtask

  initial begin
    reset     = 1'b1;
    ld_p      = 3'b000;
    ld_d      = 3'b000;
    deal_hold = 1'b0;
    tick();
    check_all("reset");
    check("reset.seed", 8'(new_card), 8'd1);
    check("reset.pscore", 8'(pscore), 8'd0);

    // Card source sweep with wrap
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      check_all("sweep");
      check("sweep.nonzero", 8'(new_card != 4'd0), 8'd1);
    end

    // Player 7 + 8
    advance_to(7);
    ld_p[0] = 1'b1;
    tick();
    ld_p = 3'b000;
    check("p2.card8", 8'(new_card), 8'd8);
    ld_p[1] = 1'b1;
    tick();
    ld_p = 3'b000;
    check_all("p2");
    check("p2.pscore", 8'(pscore), 8'd5);
    check("p2.pcount", 8'(pcount), 8'd2);

    // Dealer K, 9, then 6
    advance_to(13);
    ld_d[0] = 1'b1;
    tick();
    ld_d = 3'b000;
    advance_to(9);
    ld_d[1] = 1'b1;
    tick();
    ld_d = 3'b000;
    check("d3.dscore9", 8'(dscore), 8'd9);
    advance_to(6);
    ld_d[2] = 1'b1;
    tick();
    ld_d = 3'b000;
    check_all("d3");
    check("d3.dscore5", 8'(dscore), 8'd5);
    check("d3.dcount", 8'(dcount), 8'd3);

    // Same-edge loads of 4 while the source is held
    advance_to(4);
    ld_p[0]   = 1'b1;
    ld_d[0]   = 1'b1;
    deal_hold = 1'b1;
    tick();
    ld_p = 3'b000;
    ld_d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      check("hold.new_card", 8'(new_card), 8'd4);
      tick();
    end
    check("hold.new_card", 8'(new_card), 8'd4);
    check_all("hold");
    check("hold.pscore", 8'(pscore), 8'd2);
    check("hold.dscore", 8'(dscore), 8'd9);

    // Overwrite a filled slot, then reset over a pending load
    deal_hold = 1'b0;
    advance_to(2);
    ld_p[0] = 1'b1;
    tick();
    ld_p = 3'b000;
    check_all("reload");
    check("reload.pscore", 8'(pscore), 8'd0);
    check("reload.pcount", 8'(pcount), 8'd2);
    reset   = 1'b1;
    ld_p[1] = 1'b1;
    tick();
    ld_p  = 3'b000;
    reset = 1'b0;
    check_all("rst_mid");
    check("rst_mid.pcount", 8'(pcount), 8'd0);
    check("rst_mid.dscore", 8'(dscore), 8'd0);
    check("rst_mid.new_card", 8'(new_card), 8'd1);

    // Random play against the model
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) == 0);
      deal_hold = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 3; b++) begin
        ld_p[b] = ($urandom_range(0, 5) == 0);
        ld_d[b] = ($urandom_range(0, 5) == 0);
      end
      tick();
      check_all("rand");
    end
    reset     = 1'b0;
    deal_hold = 1'b0;
    ld_p      = 3'b000;
    ld_d      = 3'b000;

`ifdef HAND_HEX_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    advance_to(1);
    ld_p[0] = 1'b1;
    tick();
    ld_p = 3'b000;
    advance_to(10);
    ld_p[1] = 1'b1;
    tick();
    ld_p = 3'b000;
    advance_to(12);
    ld_p[2] = 1'b1;
    tick();
    ld_p = 3'b000;
    check("hex0.ace",   8'(hex0), 8'(7'b0001000));
    check("hex1.ten",   8'(hex1), 8'(7'b1000000));
    check("hex2.queen", 8'(hex2), 8'(7'b0011000));
    check("hex3.blank", 8'(hex3), 8'(7'b1111111));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
